// File: rtl/trng_controller.sv
// trng_controller: samples a ring-oscillator TRNG bit, runs a repetition-count
// health test, von Neumann debiases the samples, packs the resulting bits into
// words and buffers them in a small FIFO that the CPU drains with pop pulses.
module trng_controller #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned REP_LIMIT  = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          raw_bit,
    input  logic                          enable,
    input  logic                          clear_fault,
    input  logic                          pop,
    output logic [WORD_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          fault
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);
    localparam int unsigned BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // synchronizer
    logic sync1;
    logic sample;

    // collection path
    logic                  collecting;
    logic [DIV_W-1:0]      tick_cnt;
    logic                  sample_en;
    logic                  have_prev;
    logic                  prev_sample;
    logic [REP_W-1:0]      rep_cnt;
    logic [REP_W-1:0]      rep_next;
    logic                  trip;
    logic                  pair_have;
    logic                  pair_first;
    logic                  emit;
    logic [WORD_WIDTH-1:0] word;
    logic [WORD_WIDTH-1:0] word_shift;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  word_done;

    // FIFO
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [LVL_W-1:0]      level_next;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  drop;
    logic                  flush;

    // Two-flop synchronizer for the asynchronous raw TRNG bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sample <= 1'b0;
        end else begin
            sync1  <= raw_bit;
            sample <= sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; a health trip outranks enable dropping
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (enable) next_state = COLLECT;
            end
            COLLECT: begin
                if (trip)         next_state = FAULT;
                else if (!enable) next_state = IDLE;
            end
            FAULT: begin
                if (clear_fault) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        collecting = (state == COLLECT);
        fault      = (state == FAULT);
    end

    // Sampling, health test, debias and packing decisions for this cycle
    always_comb begin
        sample_en  = collecting && (tick_cnt == DIV_W'(SAMPLE_DIV - 1));
        if (!have_prev || (sample != prev_sample)) begin
            rep_next = REP_W'(1);
        end else begin
            rep_next = rep_cnt + REP_W'(1);
        end
        trip       = sample_en && (rep_next == REP_W'(REP_LIMIT));
        // pair "10" emits 1 and "01" emits 0, so the emitted bit is the first of the pair
        emit       = sample_en && pair_have && (pair_first != sample);
        word_shift = {word[WORD_WIDTH-2:0], pair_first};
        word_done  = emit && (bit_cnt == BIT_W'(WORD_WIDTH - 1));
    end

    // Collection state; everything is discarded whenever COLLECT is not held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt    <= '0;
            have_prev   <= 1'b0;
            prev_sample <= 1'b0;
            rep_cnt     <= '0;
            pair_have   <= 1'b0;
            pair_first  <= 1'b0;
            word        <= '0;
            bit_cnt     <= '0;
        end else if (!collecting || (next_state != COLLECT)) begin
            tick_cnt    <= '0;
            have_prev   <= 1'b0;
            prev_sample <= 1'b0;
            rep_cnt     <= '0;
            pair_have   <= 1'b0;
            pair_first  <= 1'b0;
            word        <= '0;
            bit_cnt     <= '0;
        end else begin
            if (sample_en) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + DIV_W'(1);
            end
            if (sample_en) begin
                have_prev   <= 1'b1;
                prev_sample <= sample;
                rep_cnt     <= rep_next;
                pair_have   <= !pair_have;
                if (!pair_have) pair_first <= sample;
            end
            if (emit) begin
                word <= word_shift;
                if (word_done) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

    // FIFO control: pop is judged on the pre-push level, so a full FIFO accepts push+pop
    always_comb begin
        flush    = trip;
        pop_ok   = pop && (level != '0);
        push_req = word_done && !trip;
        push_ok  = push_req && ((level != LVL_W'(FIFO_DEPTH)) || pop_ok);
        drop     = push_req && !push_ok;
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push_ok && !pop_ok) begin
            level_next = level + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_next = level - LVL_W'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= word_shift;
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            end
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == LVL_W'(FIFO_DEPTH));
        end
    end

    // Read port: popped word and its one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop_ok;
            if (pop_ok) data_out <= mem[rd_ptr];
        end
    end

    // Sticky overflow flag, acknowledged by clear_fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_fault) begin
            overflow <= 1'b0;
        end
    end

endmodule
